// File: rtl/eq_pkg.sv
// Shared equalizer types: the biquad coefficient record and its Q2.30 constants.
// The biquad engine imports this same package.
package eq_pkg;

  localparam int COEF_W = 32;
  localparam logic [COEF_W-1:0] UNITY = 32'h4000_0000;

  typedef struct packed {
    logic signed [COEF_W-1:0] b0;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
    logic signed [COEF_W-1:0] a1;
    logic signed [COEF_W-1:0] a2;
  } biquad_coef_t;

  localparam biquad_coef_t PASSTHROUGH = '{
    b0: UNITY,
    b1: '0,
    b2: '0,
    a1: '0,
    a2: '0
  };

endpackage

// File: rtl/eq_coef_bank.sv
// Double-buffered biquad coefficient store: parsed sets land in a shadow bank and
// are committed atomically to the active bank at the next audio sample tick.
module eq_coef_bank
  import eq_pkg::*;
#(
  parameter int unsigned N_FILT = 10,
  localparam int IDX_W = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_set_coef,
  input  logic [7:0]        i_set_filt,
  input  logic [COEF_W-1:0] i_b0,
  input  logic [COEF_W-1:0] i_b1,
  input  logic [COEF_W-1:0] i_b2,
  input  logic [COEF_W-1:0] i_a1,
  input  logic [COEF_W-1:0] i_a2,
  input  logic              i_sample_tick,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [COEF_W-1:0] o_b0,
  output logic [COEF_W-1:0] o_b1,
  output logic [COEF_W-1:0] o_b2,
  output logic [COEF_W-1:0] o_a1,
  output logic [COEF_W-1:0] o_a2,
  output logic              o_pending,
  output logic              o_commit,
  output logic              o_drop,
  output logic [15:0]       o_commit_cnt
);

  // Strobes only: i_set_coef and i_sample_tick are single-cycle pulses with no
  // backpressure; every pulse is consumed on the edge where it is seen.

  biquad_coef_t            shadow [N_FILT];
  biquad_coef_t            active [N_FILT];
  logic [N_FILT-1:0]       pend_mask;
  biquad_coef_t            rd_q;
  biquad_coef_t            wr_coef;
  logic                    wr_ok;
  logic                    rd_ok;
  logic [N_FILT-1:0]       wr_bit;
  logic                    do_commit;

  always_comb begin
    wr_coef   = '{b0: i_b0, b1: i_b1, b2: i_b2, a1: i_a1, a2: i_a2};
    wr_ok     = i_set_coef && (32'(i_set_filt) < N_FILT);
    rd_ok     = 32'(i_rd_idx) < N_FILT;
    do_commit = i_sample_tick && (|pend_mask);
    wr_bit    = '0;
    if (wr_ok) wr_bit[i_set_filt[IDX_W-1:0]] = 1'b1;
  end

  // Non-blocking semantics give the required ordering: a same-cycle write and
  // commit see the pre-edge shadow, and the new write keeps its bit pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(N_FILT); k++) begin
        shadow[k] <= PASSTHROUGH;
        active[k] <= PASSTHROUGH;
      end
      pend_mask    <= '0;
      rd_q         <= '0;
      o_commit     <= 1'b0;
      o_drop       <= 1'b0;
      o_commit_cnt <= '0;
    end else begin
      for (int k = 0; k < int'(N_FILT); k++) begin
        if (do_commit && pend_mask[k]) active[k] <= shadow[k];
      end
      if (wr_ok) shadow[i_set_filt[IDX_W-1:0]] <= wr_coef;
      pend_mask    <= (i_sample_tick ? '0 : pend_mask) | wr_bit;
      rd_q         <= rd_ok ? active[i_rd_idx] : PASSTHROUGH;
      o_commit     <= do_commit;
      o_drop       <= i_set_coef && !wr_ok;
      if (do_commit) o_commit_cnt <= o_commit_cnt + 16'd1;
    end
  end

  assign o_b0      = rd_q.b0;
  assign o_b1      = rd_q.b1;
  assign o_b2      = rd_q.b2;
  assign o_a1      = rd_q.a1;
  assign o_a2      = rd_q.a2;
  assign o_pending = |pend_mask;

endmodule

// File: tb/tb_eq_coef_bank.sv
// Directed bench for eq_coef_bank: write/commit ordering, overwrite, simultaneous
// write+tick, invalid indices and asynchronous reset while updates are pending.
module tb_eq_coef_bank;
  import eq_pkg::*;

  localparam int N_FILT = 10;
  localparam int IDX_W  = 4;
  localparam logic [31:0] UNITY_V = 32'h4000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              set_coef = 1'b0;
  logic [7:0]        set_filt = '0;
  logic [COEF_W-1:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
  logic              sample_tick = 1'b0;
  logic [IDX_W-1:0]  rd_idx = '0;
  logic [COEF_W-1:0] o_b0, o_b1, o_b2, o_a1, o_a2;
  logic              pending, commit, drop;
  logic [15:0]       commit_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  eq_coef_bank #(.N_FILT(N_FILT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_set_coef(set_coef), .i_set_filt(set_filt),
    .i_b0(b0), .i_b1(b1), .i_b2(b2), .i_a1(a1), .i_a2(a2),
    .i_sample_tick(sample_tick), .i_rd_idx(rd_idx),
    .o_b0(o_b0), .o_b1(o_b1), .o_b2(o_b2), .o_a1(o_a1), .o_a2(o_a2),
    .o_pending(pending), .o_commit(commit), .o_drop(drop),
    .o_commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] filt, input logic [31:0] v0, v1, v2, v3, v4);
    set_coef = 1'b1; set_filt = filt;
    b0 = v0; b1 = v1; b2 = v2; a1 = v3; a2 = v4;
    step();
    set_coef = 1'b0;
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] idx);
    rd_idx = idx;
    step();
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (o_b0 !== 32'h0) begin
      tests_failed++; $display("FAIL reset_ob0 got %h want 0", o_b0);
    end
    step();
    rst_n = 1'b1;
    do_read(4'd3);
    tests_run++;
    if (o_b0 !== UNITY_V || o_b1 !== 0 || o_b2 !== 0 || o_a1 !== 0 || o_a2 !== 0) begin
      tests_failed++;
      $display("FAIL reset_read3 got %h %h %h %h %h want %h 0 0 0 0", o_b0, o_b1, o_b2, o_a1, o_a2, UNITY_V);
    end
    tests_run++;
    if (pending !== 1'b0 || commit_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_status pending=%b cnt=%0d want 0 0", pending, commit_cnt);
    end
  endtask

  task automatic test_write_commit();
    do_write(8'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555);
    tests_run++;
    if (pending !== 1'b1) begin
      tests_failed++; $display("FAIL wc_pending got %b want 1", pending);
    end
    do_read(4'd2);
    tests_run++;
    if (o_b0 !== UNITY_V || o_b1 !== 0) begin
      tests_failed++; $display("FAIL wc_pre_tick got b0=%h b1=%h want %h 0", o_b0, o_b1, UNITY_V);
    end
    // Read presented in the tick cycle still returns the old value.
    rd_idx = 4'd2;
    do_tick();
    tests_run++;
    if (o_b0 !== UNITY_V) begin
      tests_failed++; $display("FAIL wc_tick_cycle_read got %h want %h", o_b0, UNITY_V);
    end
    tests_run++;
    if (commit !== 1'b1 || commit_cnt !== 16'd1 || pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL wc_commit got commit=%b cnt=%0d pending=%b want 1 1 0", commit, commit_cnt, pending);
    end
    do_read(4'd2);
    tests_run++;
    if (commit !== 1'b0) begin
      tests_failed++; $display("FAIL wc_commit_pulse got %b want 0", commit);
    end
    tests_run++;
    if (o_b0 !== 32'h1111_1111 || o_b1 !== 32'h2222_2222 || o_b2 !== 32'h3333_3333 ||
        o_a1 !== 32'h4444_4444 || o_a2 !== 32'h5555_5555) begin
      tests_failed++;
      $display("FAIL wc_post_tick got %h %h %h %h %h want 11111111..55555555", o_b0, o_b1, o_b2, o_a1, o_a2);
    end
  endtask

  task automatic test_back_to_back();
    do_write(8'd4, 32'd1, 0, 0, 0, 0);
    do_write(8'd4, 32'd2, 0, 0, 0, 0);
    do_write(8'd7, 32'd3, 0, 0, 0, 32'hDEAD_BEEF);
    do_tick();
    tests_run++;
    if (commit !== 1'b1 || commit_cnt !== 16'd2) begin
      tests_failed++; $display("FAIL b2b_commit got commit=%b cnt=%0d want 1 2", commit, commit_cnt);
    end
    do_read(4'd4);
    tests_run++;
    if (o_b0 !== 32'd2 || commit !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_filt4 got b0=%h commit=%b want 2 0", o_b0, commit);
    end
    do_read(4'd7);
    tests_run++;
    if (o_b0 !== 32'd3 || o_a2 !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL b2b_filt7 got b0=%h a2=%h want 3 deadbeef", o_b0, o_a2);
    end
  endtask

  task automatic test_simultaneous();
    do_write(8'd1, 32'hAAAA_0001, 0, 0, 0, 0);
    set_coef = 1'b1; set_filt = 8'd1; b0 = 32'hBBBB_0002;
    sample_tick = 1'b1;
    step();
    set_coef = 1'b0; sample_tick = 1'b0;
    tests_run++;
    if (commit !== 1'b1 || pending !== 1'b1) begin
      tests_failed++; $display("FAIL sim_flags got commit=%b pending=%b want 1 1", commit, pending);
    end
    do_read(4'd1);
    tests_run++;
    if (o_b0 !== 32'hAAAA_0001) begin
      tests_failed++; $display("FAIL sim_old_value got %h want aaaa0001", o_b0);
    end
    do_tick();
    do_read(4'd1);
    tests_run++;
    if (o_b0 !== 32'hBBBB_0002 || pending !== 1'b0 || commit_cnt !== 16'd4) begin
      tests_failed++;
      $display("FAIL sim_second got b0=%h pending=%b cnt=%0d want bbbb0002 0 4", o_b0, pending, commit_cnt);
    end
  endtask

  task automatic test_invalid();
    do_write(8'(N_FILT), 32'h0BAD_0BAD, 0, 0, 0, 0);
    tests_run++;
    if (drop !== 1'b1 || pending !== 1'b0) begin
      tests_failed++; $display("FAIL inv_drop got drop=%b pending=%b want 1 0", drop, pending);
    end
    do_read(4'(N_FILT));
    tests_run++;
    if (drop !== 1'b0 || o_b0 !== UNITY_V || o_a2 !== 0) begin
      tests_failed++; $display("FAIL inv_read got drop=%b b0=%h a2=%h want 0 %h 0", drop, o_b0, o_a2, UNITY_V);
    end
    do_write(8'd255, 32'h0BAD_0BAD, 0, 0, 0, 0);
    do_tick();
    tests_run++;
    if (commit !== 1'b0 || commit_cnt !== 16'd4) begin
      tests_failed++; $display("FAIL inv_idle_tick got commit=%b cnt=%0d want 0 4", commit, commit_cnt);
    end
    do_read(4'd2);
    tests_run++;
    if (o_b0 !== 32'h1111_1111) begin
      tests_failed++; $display("FAIL inv_bank_intact got %h want 11111111", o_b0);
    end
    do_read(4'd9);
    tests_run++;
    if (o_b0 !== UNITY_V) begin
      tests_failed++; $display("FAIL inv_last_valid got %h want %h", o_b0, UNITY_V);
    end
  endtask

  task automatic test_reset_pending();
    do_write(8'd0, 32'h7FFF_FFFF, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (pending !== 1'b0 || o_b0 !== 32'h0 || commit_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstp_async got pending=%b b0=%h cnt=%0d want 0 0 0", pending, o_b0, commit_cnt);
    end
    step();
    rst_n = 1'b1;
    do_tick();
    tests_run++;
    if (commit !== 1'b0 || commit_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL rstp_no_commit got commit=%b cnt=%0d want 0 0", commit, commit_cnt);
    end
    do_read(4'd0);
    tests_run++;
    if (o_b0 !== UNITY_V) begin
      tests_failed++; $display("FAIL rstp_filt0 got %h want %h", o_b0, UNITY_V);
    end
    do_read(4'd2);
    tests_run++;
    if (o_b0 !== UNITY_V || o_b1 !== 0) begin
      tests_failed++; $display("FAIL rstp_filt2 got b0=%h b1=%h want %h 0", o_b0, o_b1, UNITY_V);
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_back_to_back();
    test_simultaneous();
    test_invalid();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eq_coef_bank.md
# eq_coef_bank

Double-buffered coefficient store for the equalizer's biquad cascade. Sits directly downstream of the UDP coefficient parser: it captures each parsed coefficient set (filter index plus b0, b1, b2, a1, a2) into a shadow bank. All pending updates are committed atomically into the active bank on the next audio sample boundary, so the biquad engine never sees a half-updated filter. The engine reads the active bank through an indexed, registered read port.

## Interface
- N_FILT, 10, number of biquad sections stored (1..255)
- COEF_W, 32, coefficient width, signed Q2.30
- UNITY, 32'h4000_0000, value of 1.0 in Q2.30; used for the passthrough default
- i_clk  in  1  clock
- i_rst_n  in  1  reset: asynchronous, active-low
- i_set_coef  in  1  one-cycle strobe; coefficient set on i_set_filt/i_b0..i_a2 is valid
- i_set_filt  in  8  target filter index
- i_b0, i_b1, i_b2, i_a1, i_a2  in  COEF_W each  coefficients, valid with i_set_coef
- i_sample_tick  in  1  one-cycle strobe at the audio sample boundary; commit point
- i_rd_idx  in  IDX_W = max(1,$clog2(N_FILT))  read index from the biquad engine
- o_b0, o_b1, o_b2, o_a1, o_a2  out  COEF_W each  active coefficients for the i_rd_idx sampled one cycle earlier
- o_pending  out  1  at least one shadow entry awaits commit
- o_commit  out  1  one-cycle pulse: a commit occurred on the previous cycle's tick
- o_drop  out  1  one-cycle pulse: the previous cycle's i_set_coef had an out-of-range index
- o_commit_cnt  out  16  number of commits performed; wraps 16'hFFFF -> 0

## Operation
- Storage: shadow[N_FILT] and active[N_FILT] of biquad_coef_t {b0,b1,b2,a1,a2}; pend_mask[N_FILT].
- Reset values:
  - shadow and active entries all = passthrough {UNITY,0,0,0,0}.
  - pend_mask = 0; o_b*/o_a* = 0; o_pending, o_commit, o_drop = 0; o_commit_cnt = 0.
- Write (i_set_coef=1, i_set_filt < N_FILT): shadow[i_set_filt] <= inputs; pend_mask[i_set_filt] <= 1.
  - A second write to the same index before a tick overwrites it; last write wins.
- Write with i_set_filt >= N_FILT: ignored (no state change); o_drop=1 next cycle.
- Commit (i_sample_tick=1 and pend_mask != 0): for every set bit k, active[k] <= shadow[k], all in one cycle.
  - pend_mask cleared for those bits, except any bit set by a same-cycle write.
  - o_commit=1 next cycle; o_commit_cnt increments.
- i_sample_tick with pend_mask == 0: no effect; no o_commit; counter unchanged.
- Simultaneous write and tick: the commit uses shadow contents as they were before this cycle. The new write lands in shadow and leaves its bit pending for the next tick. This holds even when the same index was already pending: the old value is committed and the new value stays pending.
- Read: o_* <= active[i_rd_idx] every cycle.
  - i_rd_idx >= N_FILT returns passthrough {UNITY,0,0,0,0}.
- o_pending = |pend_mask, driven from the registered mask.
- No arithmetic on coefficients; values are stored bit-exact.

## Timing
- Write to shadow: 1 cycle. Visible to the read port only after a commit.
- Commit: the tick at edge T updates active at T. A read with i_rd_idx presented in cycle T+1 returns new data on o_* at T+2.
- A read presented in the tick cycle itself returns the old value.
- Read latency: 1 cycle, fully pipelined; a new index is accepted every cycle.
- o_commit and o_drop are registered single-cycle pulses. o_pending updates 1 cycle after the write or tick edge.
- Back-to-back i_set_coef every cycle is supported; no backpressure exists.
- Reset asserted mid-operation: pending updates are discarded and both banks return to passthrough immediately (asynchronous).

## Structure
- eq_pkg (shared equalizer package) holds:
  - typedef biquad_coef_t (packed struct of five signed [COEF_W-1:0] fields, b0 in the MSBs);
  - COEF_W and UNITY constants;
  - PASSTHROUGH constant of type biquad_coef_t.
- The biquad engine imports the same package.
- Single module, no sub-modules. Banks are flip-flop arrays with no RAM inference; N_FILT is small and the commit needs parallel copy.

## Test plan
- Reset: o_b0=0 before the first read. After reset, i_rd_idx=3 -> o_b0=32'h4000_0000 and o_b1..o_a2=0; o_pending=0, o_commit_cnt=0.
- Write and commit:
  - write filt 2 with b0=32'h1111_1111 ... a2=32'h5555_5555; o_pending=1.
  - read idx 2 before the tick -> passthrough.
  - after the tick -> the new values; o_commit pulses once; o_commit_cnt=1.
- Overwrite and multi-commit:
  - write filt 4 with b0=1, then filt 4 with b0=2, then filt 7 with b0=3.
  - one tick -> active[4].b0=2, active[7].b0=3; exactly one o_commit.
- Simultaneous events:
  - filt 1 pending with b0=A; a write of filt 1 with b0=B in the tick cycle -> active[1].b0=A and o_pending stays 1.
  - next tick -> active[1].b0=B, o_pending=0, o_commit_cnt incremented by 2 in total.
- Invalid index: i_set_filt=N_FILT -> o_drop pulses 1 cycle, o_pending stays 0, no bank change. i_rd_idx=N_FILT -> passthrough.
- Reset mid-pending: write filt 0 with b0=32'h7FFF_FFFF, assert i_rst_n=0 before the tick, release, then tick -> active[0] is passthrough and no o_commit.
